quad_step_decoder: RTL and testbench
====================================

// Module: quad_step_decoder
// PURPOSE
//   Quadrature decoder with an integrated position counter. Turns a pair of
//   incremental-encoder phase inputs (A/B) into count steps and direction.
//   It sits between the raw pins and the counter logic, producing the
//   enable/direction stimulus the up/down counter consumes. It also keeps
//   its own WIDTH-bit position, which can be loaded.
// PARAMETERS
//   WIDTH  8  position counter / load value width
//   FILT   2  glitch filter depth, in cycles an input must hold a new level (1..15)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   enc_a       in   1      encoder phase A, asynchronous to clk
//   enc_b       in   1      encoder phase B, asynchronous to clk
//   load        in   1      load load_val into count (priority over steps)
//   load_val    in   WIDTH  value loaded on load
//   clr_err     in   1      clear sticky err
//   count       out  WIDTH  current position
//   step_pulse  out  1      one-cycle strobe, high in the cycle count moved by a step
//   step_dir    out  1      direction of last step: 0 = up (+1), 1 = down (-1)
//   err         out  1      sticky illegal-transition flag
// BEHAVIOUR
//   Reset
//     - Async on rst_n low: count=0, step_pulse=0, step_dir=0, err=0.
//     - Synchronisers, filters and primed flag are cleared.
//   Input path
//     - enc_a and enc_b each pass through a 2-flop synchroniser.
//     - Each has an independent filter counter. The filtered level takes the
//       synced level after the synced level differs from it for FILT
//       consecutive cycles. Any return to the old level restarts the count.
//   Priming
//     - The first filtered {A,B} after reset is captured as the previous state
//       without producing a step, err or pulse.
//     - The primed flag is then set.
//   Decode
//     - Compare the previous filtered {A,B} with the current one.
//     - Up (+1): 00->01->11->10->00.
//     - Down (-1): 00->10->11->01->00.
//     - No change: nothing happens.
//     - Both bits change in one cycle: err <= 1, count unchanged, no pulse.
//   Count update (registered)
//     - On a step: count <= count +/- 1, modulo 2^WIDTH (wraps FF->00 and 00->FF).
//     - step_pulse=1 for exactly one cycle; step_dir updated; step_dir holds
//       between steps.
//   Latency
//     - An edge sampled on clock edge n changes count on edge n+FILT+2, i.e.
//       FILT+3 edges counting the sampling edge.
//     - Constant; filter depth is the only variable.
//   Simultaneous events
//     - load and step in the same cycle: count <= load_val, step_pulse=0, and
//       the step is consumed (previous state still advances).
//     - load, when asserted, always overrides a decoded step.
//     - clr_err and an illegal transition in the same cycle: err stays 1 (set wins).
//   Reset mid-operation
//     - All state is cleared immediately and the decoder re-primes from the
//       current pin levels.
//     - No step is generated from the pre-reset state.
//   Outputs are pure register outputs; no combinational path from inputs.
// TESTING (FILT=2, WIDTH=8)
//   1 reset, A=B=0 held, then 4 forward phases 01,11,10,00, each held 10 cycles
//     -> count 0->1->2->3->4; 4 single-cycle step_pulse; step_dir=0;
//     each update 5 edges after the pin change.
//   2 from count=0, one reverse phase 00->10
//     -> count=0xFF; step_dir=1; one pulse.
//   3 A pulsed high for 1 cycle (synced) then back low
//     -> count unchanged, no pulse, err=0.
//   4 A and B toggled together 00->11
//     -> err=1, count unchanged, no pulse; clr_err 1 cycle -> err=0;
//     repeat with clr_err asserted in the same cycle as the illegal transition -> err=1.
//   5 load=1, load_val=0x80 in the same cycle as a forward step
//     -> count=0x80, step_pulse=0; next forward step -> 0x81.
//   6 rst_n low mid-sequence with pins at 11, then released
//     -> count=0 during reset; after re-prime, count stays 0 and no pulse;
//     next phase 11->10 -> count=1.

Source files
------------

// File: rtl/quad_step_decoder.sv
// ============================================================================
// Module  : quad_step_decoder
// Brief   : Quadrature A/B decoder with glitch filter and loadable position.
// Revision: 1.0
// ============================================================================
`default_nettype none

module quad_step_decoder #(
  parameter int WIDTH = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             err
);

  localparam logic [3:0] C_FILT_LAST = 4'(FILT - 1);

  // Bit 1 carries phase A, bit 0 carries phase B throughout.
  logic [1:0] w_pins;
  logic [1:0] w_sync;
  logic [1:0] w_filt;

  // r_vld marks when the synchroniser outputs hold real pin samples.
  logic [1:0] r_vld;
  logic       r_primed;
  logic [1:0] r_prev;
  logic       w_seed;

  assign w_pins = {enc_a, enc_b};
  assign w_seed = r_vld[1] & ~r_primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 2'b00;
    end else begin
      r_vld <= {r_vld[0], 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic       r_s1;
      logic       r_s2;
      logic       r_lvl;
      logic [3:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_lvl <= 1'b0;
          r_cnt <= 4'd0;
        end else begin
          r_s1 <= w_pins[gi];
          r_s2 <= r_s1;
          if (w_seed) begin
            // First valid sample is adopted directly so priming sees real pins.
            r_lvl <= r_s2;
            r_cnt <= 4'd0;
          end else if (r_s2 != r_lvl) begin
            if (r_cnt == C_FILT_LAST) begin
              r_lvl <= r_s2;
              r_cnt <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_cnt <= 4'd0;
          end
        end
      end

      assign w_sync[gi] = r_s2;
      assign w_filt[gi] = r_lvl;
    end
  endgenerate

  logic w_up;
  logic w_dn;
  logic w_ill;

  always_comb begin
    w_up  = 1'b0;
    w_dn  = 1'b0;
    w_ill = 1'b0;
    if (r_primed) begin
      unique case ({r_prev, w_filt})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_up  = 1'b1;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_dn  = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_ill = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed   <= 1'b0;
      r_prev     <= 2'b00;
      count      <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      err        <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (w_seed) begin
        r_prev   <= w_sync;
        r_primed <= 1'b1;
      end else if (r_primed) begin
        r_prev <= w_filt;
      end

      // A load swallows any step decoded in the same cycle.
      if (load) begin
        count <= load_val;
      end else if (w_up) begin
        count      <= count + 1'b1;
        step_pulse <= 1'b1;
        step_dir   <= 1'b0;
      end else if (w_dn) begin
        count      <= count - 1'b1;
        step_pulse <= 1'b1;
        step_dir   <= 1'b1;
      end

      if (w_ill) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
// ============================================================================
// Module  : tb_quad_step_decoder
// Brief   : Directed vector bench for quad_step_decoder (WIDTH=8, FILT=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_quad_step_decoder;

  logic       clk;
  logic       rst_n;
  logic       enc_a;
  logic       enc_b;
  logic       load;
  logic [7:0] load_val;
  logic       clr_err;
  logic [7:0] count;
  logic       step_pulse;
  logic       step_dir;
  logic       err;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;

  quad_step_decoder #(.WIDTH(8), .FILT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .load       (load),
    .load_val   (load_val),
    .clr_err    (clr_err),
    .count      (count),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step_pulse === 1'b1) pulse_total++;
  end

  typedef struct {
    logic [1:0] ab;
    logic       ld;
    logic [7:0] ld_val;
    logic       clr;
    logic [7:0] exp_count;
    logic       exp_pulse;
    logic       exp_dir;
    logic       exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    load     = 1'b0;
    load_val = 8'h00;
    clr_err  = 1'b0;
  endtask

  initial begin
    logic [7:0] prev_count;
    int         p0;
    logic       saw_pulse;

    vecs[0]  = '{2'b01, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b11, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 1'b1, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 1'b0, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", count, 8'h00);
    chk("reset_pulse", step_pulse, 1'b0);
    chk("reset_dir", step_dir, 1'b0);
    chk("reset_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("primed_count", count, 8'h00);
    chk("primed_err", err, 1'b0);

    prev_count = 8'h00;
    for (int i = 0; i < 13; i++) begin
      {enc_a, enc_b} = vecs[i].ab;
      load     = vecs[i].ld;
      load_val = vecs[i].ld_val;
      clr_err  = vecs[i].clr;
      repeat (4) @(posedge clk);
      #1;
      if (!vecs[i].ld) chk($sformatf("v%0d_early_count", i), count, prev_count);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("v%0d_pulse", i), step_pulse, vecs[i].exp_pulse);
      chk($sformatf("v%0d_dir", i), step_dir, vecs[i].exp_dir);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      drive_idle();
      saw_pulse = 1'b0;
      repeat (5) begin
        @(posedge clk);
        #1;
        saw_pulse |= step_pulse;
      end
      chk($sformatf("v%0d_no_extra_pulse", i), saw_pulse, 1'b0);
      chk($sformatf("v%0d_hold_count", i), count, vecs[i].exp_count);
      prev_count = vecs[i].exp_count;
    end

    // Reset mid-operation with pins parked at 11.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", count, 8'h00);
    chk("midrst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulse_total;
    repeat (12) @(posedge clk);
    #2;
    chk("reprime_count", count, 8'h00);
    chk("reprime_pulses", pulse_total - p0, 0);
    chk("reprime_err", err, 1'b0);
    {enc_a, enc_b} = 2'b10;
    repeat (5) @(posedge clk);
    #1;
    chk("after_rst_step_count", count, 8'h01);
    chk("after_rst_step_pulse", step_pulse, 1'b1);
    chk("after_rst_step_dir", step_dir, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    {enc_a, enc_b} = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    chk("to00_count", count, 8'h02);

    // Single-cycle glitch on A must be filtered out.
    p0 = pulse_total;
    enc_a = 1'b1;
    @(posedge clk);
    #1;
    enc_a = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("glitch_count", count, 8'h02);
    chk("glitch_pulses", pulse_total - p0, 0);
    chk("glitch_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
